// File: rtl/waveform_pkg.sv
// Shared sample type and analyzer state encoding for the waveform generator/analyzer pair.
package waveform_pkg;

  localparam int SAMPLE_W = 24;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [0:0] {
    SEEK    = 1'b0,
    MEASURE = 1'b1
  } analyzer_state_t;

endpackage

// File: rtl/peak_tracker.sv
// Running signed maximum/minimum over the samples of one waveform cycle.
module peak_tracker #(
  parameter int DATA_W = 24
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     restart_i,
  input  logic                     update_i,
  input  logic signed [DATA_W-1:0] sample_i,
  output logic signed [DATA_W-1:0] max_o,
  output logic signed [DATA_W-1:0] min_o
);

  logic signed [DATA_W-1:0] max_q, max_d;
  logic signed [DATA_W-1:0] min_q, min_d;

  // restart seeds both extremes with the sample; update folds it in
  always_comb begin
    max_d = max_q;
    min_d = min_q;
    if (restart_i) begin
      max_d = sample_i;
      min_d = sample_i;
    end else if (update_i) begin
      if (sample_i > max_q) begin
        max_d = sample_i;
      end else begin
        max_d = max_q;
      end
      if (sample_i < min_q) begin
        min_d = sample_i;
      end else begin
        min_d = min_q;
      end
    end else begin
      max_d = max_q;
      min_d = min_q;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      max_q <= '0;
      min_q <= '0;
    end else begin
      max_q <= max_d;
      min_q <= min_d;
    end
  end

  assign max_o = max_q;
  assign min_o = min_q;

endmodule

// File: rtl/waveform_analyzer.sv
// Rising zero-crossing detector with hysteresis; reports period in samples and
// the signed peaks of each complete waveform cycle.
module waveform_analyzer
  import waveform_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int CNT_W  = 16,
  parameter int HYST   = 0
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic signed [DATA_W-1:0] sampleIn,
  input  logic                     sampleValid,
  output logic        [CNT_W-1:0]  period,
  output logic signed [DATA_W-1:0] peakPos,
  output logic signed [DATA_W-1:0] peakNeg,
  output logic                     resultValid,
  output logic                     locked,
  output logic                     overflow
);

  localparam logic signed [DATA_W-1:0] HYST_POS = DATA_W'(HYST);
  localparam logic signed [DATA_W-1:0] HYST_NEG = -HYST_POS;
  localparam logic        [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic        [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  analyzer_state_t          state_q, state_d;
  logic                     armed_q, armed_d;
  logic        [CNT_W-1:0]  count_q, count_d;
  logic        [CNT_W-1:0]  period_q, period_d;
  logic signed [DATA_W-1:0] peak_pos_q, peak_pos_d;
  logic signed [DATA_W-1:0] peak_neg_q, peak_neg_d;
  logic                     result_valid_q, result_valid_d;
  logic                     locked_q, locked_d;
  logic                     overflow_q, overflow_d;

  logic                     crossing_s;
  logic                     arm_s;
  logic                     trk_restart_s;
  logic                     trk_update_s;
  logic signed [DATA_W-1:0] trk_max_s;
  logic signed [DATA_W-1:0] trk_min_s;

  // Crossing uses the pre-sample armed flag; the two thresholds never overlap
  assign crossing_s = armed_q && (sampleIn >= HYST_POS);
  assign arm_s      = (sampleIn < HYST_NEG);

  peak_tracker #(
    .DATA_W(DATA_W)
  ) u_peak_tracker (
    .Clock    (Clock),
    .Reset    (Reset),
    .restart_i(trk_restart_s),
    .update_i (trk_update_s),
    .sample_i (sampleIn),
    .max_o    (trk_max_s),
    .min_o    (trk_min_s)
  );

  always_comb begin
    state_d        = state_q;
    armed_d        = armed_q;
    count_d        = count_q;
    period_d       = period_q;
    peak_pos_d     = peak_pos_q;
    peak_neg_d     = peak_neg_q;
    result_valid_d = 1'b0;
    locked_d       = locked_q;
    overflow_d     = 1'b0;
    trk_restart_s  = 1'b0;
    trk_update_s   = 1'b0;
    if (sampleValid) begin
      if (crossing_s) begin
        armed_d = 1'b0;
      end else if (arm_s) begin
        armed_d = 1'b1;
      end else begin
        armed_d = armed_q;
      end
      case (state_q)
        SEEK: begin
          if (crossing_s) begin
            state_d       = MEASURE;
            count_d       = CNT_ONE;
            trk_restart_s = 1'b1;
          end else begin
            state_d = SEEK;
          end
        end
        MEASURE: begin
          if (crossing_s) begin
            period_d       = count_q;
            peak_pos_d     = trk_max_s;
            peak_neg_d     = trk_min_s;
            result_valid_d = 1'b1;
            locked_d       = 1'b1;
            count_d        = CNT_ONE;
            trk_restart_s  = 1'b1;
          end else if (count_q == CNT_MAX) begin
            // Saturated: abandon the cycle and hunt for a fresh arm/crossing
            overflow_d = 1'b1;
            locked_d   = 1'b0;
            armed_d    = 1'b0;
            state_d    = SEEK;
            count_d    = '0;
          end else begin
            count_d      = count_q + CNT_ONE;
            trk_update_s = 1'b1;
          end
        end
        default: begin
          state_d = SEEK;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q        <= SEEK;
      armed_q        <= 1'b0;
      count_q        <= '0;
      period_q       <= '0;
      peak_pos_q     <= '0;
      peak_neg_q     <= '0;
      result_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      armed_q        <= armed_d;
      count_q        <= count_d;
      period_q       <= period_d;
      peak_pos_q     <= peak_pos_d;
      peak_neg_q     <= peak_neg_d;
      result_valid_q <= result_valid_d;
      locked_q       <= locked_d;
      overflow_q     <= overflow_d;
    end
  end

  assign period      = period_q;
  assign peakPos     = peak_pos_q;
  assign peakNeg     = peak_neg_q;
  assign resultValid = result_valid_q;
  assign locked      = locked_q;
  assign overflow    = overflow_q;

endmodule
